// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for rv32i_cpu: FETCH/DECODE/EXEC/MEM/WB.
// Shares one memory port between fetch and load/store; sticky fault state.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   pc, alu_result       fetch address / load-store address
//   mem_op, mem_write_mask, funct3, regfile_src, funct3_valid  decode inputs
//   mem_ready            memory handshake (may be combinational)
//   mem_req/we/wmask/addr  memory port
//   instr_en, load_en, regfile_we, pc_en  datapath enables
//   fault, fault_cause, state             status / debug
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned
// half/word accesses in EXEC (cause 11) instead of issuing them.
`timescale 1ns/1ps

module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [1:0]  mem_op,
  input  logic [3:0]  mem_write_mask,
  input  logic [2:0]  funct3,
  input  logic [2:0]  regfile_src,
  input  logic        funct3_valid,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic        instr_en,
  output logic        load_en,
  output logic        regfile_we,
  output logic        pc_en,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [2:0] REG_SRC_NONE = 3'd0;

  localparam logic [1:0] CAUSE_F3 = 2'b01;
  localparam logic [1:0] CAUSE_TO = 2'b10;
  localparam logic [1:0] CAUSE_MA = 2'b11;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Zero timeout disables the watchdog entirely.
  localparam bit         TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef MISALIGN_TRAP_EN
  localparam bit MA_TRAP = 1'b1;
`else
  localparam bit MA_TRAP = 1'b0;
`endif

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;

  logic       in_fetch;
  logic       in_mem;
  logic       in_wb;
  logic       in_fault;
  logic       is_load;
  logic       is_store;
  logic       is_ls;
  logic       misaligned;
  logic       ma_hit;
  logic       to_hit;
  logic [7:0] wait_inc;
  logic       unused_f3;

  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign in_wb    = (state_q == S_WB);
  assign in_fault = (state_q == S_FAULT);

  assign is_load  = (mem_op == MEM_OP_LOAD);
  assign is_store = (mem_op == MEM_OP_STORE);
  assign is_ls    = is_load | is_store;

  // Access size lives in funct3[1:0]; bit 2 (unsigned) is irrelevant here.
  assign unused_f3 = funct3[2];

  always_comb begin
    misaligned = 1'b0;
    unique case (funct3[1:0])
      SZ_HALF: misaligned = alu_result[0];
      SZ_WORD: misaligned = |alu_result[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign ma_hit = MA_TRAP & is_ls & misaligned;

  // Counter saturates so an unlimited timeout never wraps.
  assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  assign to_hit   = TO_EN && (wait_q == TO_LAST);

  // Next state. The wait counter returns to zero in every state
  // other than a stalled FETCH/MEM, so it is clear on entry.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TO;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        if (!funct3_valid) begin
          state_d = S_FAULT;
          cause_d = CAUSE_F3;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ma_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_MA;
        end else if (mem_op != MEM_OP_NONE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
        end else if (to_hit) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TO;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Outputs are decoded from the registered state only (plus
  // mem_ready for the pulses), so they fall with async reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_wmask  = '0;
    mem_addr   = '0;
    instr_en   = 1'b0;
    load_en    = 1'b0;
    regfile_we = 1'b0;
    pc_en      = 1'b0;
    fault      = 1'b0;
    unique case (1'b1)
      in_fetch: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        instr_en = mem_ready;
      end
      in_mem: begin
        mem_req   = 1'b1;
        mem_addr  = alu_result;
        mem_we    = is_store;
        mem_wmask = is_store ? mem_write_mask : 4'b0000;
        load_en   = mem_ready & is_load;
      end
      in_wb: begin
        regfile_we = (regfile_src != REG_SRC_NONE);
        pc_en      = 1'b1;
      end
      in_fault: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fault_cause = cause_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer against a
// per-instruction expected-trace model.
`timescale 1ns/1ps

module tb_multicycle_sequencer;

  localparam int TO = 4;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] alu_result = '0;
  logic [1:0]  mem_op = '0;
  logic [3:0]  mem_write_mask = '0;
  logic [2:0]  funct3 = '0;
  logic [2:0]  regfile_src = '0;
  logic        funct3_valid = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic        instr_en;
  logic        load_en;
  logic        regfile_we;
  logic        pc_en;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [2:0]  state;

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .alu_result     (alu_result),
    .mem_op         (mem_op),
    .mem_write_mask (mem_write_mask),
    .funct3         (funct3),
    .regfile_src    (regfile_src),
    .funct3_valid   (funct3_valid),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_wmask      (mem_wmask),
    .mem_addr       (mem_addr),
    .instr_en       (instr_en),
    .load_en        (load_en),
    .regfile_we     (regfile_we),
    .pc_en          (pc_en),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        we;
    logic [3:0]  wm;
    logic [31:0] addr;
    logic        ien;
    logic        len;
    logic        rwe;
    logic        pen;
    logic        flt;
    logic [1:0]  cause;
    logic        drv;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ctl_now();
    return 32'({mem_req, mem_we, mem_wmask, instr_en, load_en,
                regfile_we, pc_en, fault, fault_cause});
  endfunction

  function automatic logic [31:0] ctl_exp(input exp_t e);
    return 32'({e.req, e.we, e.wm, e.ien, e.len,
                e.rwe, e.pen, e.flt, e.cause});
  endfunction

  task automatic compare(input exp_t e);
    check("state", 32'(state), 32'(e.st));
    check("ctl", ctl_now(), ctl_exp(e));
    if (e.req) check("addr", mem_addr, e.addr);
  endtask

  task automatic push_fault(input logic [1:0] c);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.st = 3'd7;
      e.flt = 1'b1;
      e.cause = c;
      q.push_back(e);
    end
  endtask

  // A memory phase: wait cycles, then either a ready cycle
  // or, once TO unanswered cycles have passed, a timeout.
  task automatic push_access(input exp_t base, input int waits,
                             input bit is_load, output bit to);
    exp_t e;
    int n;
    n = (waits >= TO) ? TO : waits;
    for (int i = 0; i < n; i++) begin
      e = base;
      e.drv = 1'b1;
      e.rdy = 1'b0;
      q.push_back(e);
    end
    to = (waits >= TO);
    if (!to) begin
      e = base;
      e.drv = 1'b1;
      e.rdy = 1'b1;
      if (base.st == 3'd1) e.ien = 1'b1;
      else e.len = is_load;
      q.push_back(e);
    end
  endtask

  function automatic bit mis(input logic [2:0] f3,
                             input logic [31:0] a);
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic build(input logic [31:0] a_pc, input logic [31:0] a_alu,
                       input logic [1:0] op, input logic [3:0] mk,
                       input logic [2:0] f3, input logic [2:0] src,
                       input bit f3v, input int wf, input int wm);
    exp_t e;
    bit to;
    q.delete();
    e = '0;
    e.st = 3'd1;
    e.req = 1'b1;
    e.addr = a_pc;
    push_access(e, wf, 1'b0, to);
    if (to) begin
      push_fault(2'b10);
      return;
    end
    e = '0;
    e.st = 3'd2;
    q.push_back(e);
    if (!f3v) begin
      push_fault(2'b01);
      return;
    end
    e = '0;
    e.st = 3'd3;
    q.push_back(e);
    if (TRAP && op != 2'd0 && mis(f3, a_alu)) begin
      push_fault(2'b11);
      return;
    end
    if (op != 2'd0) begin
      e = '0;
      e.st = 3'd4;
      e.req = 1'b1;
      e.addr = a_alu;
      e.we = (op == 2'd2);
      e.wm = (op == 2'd2) ? mk : 4'b0000;
      push_access(e, wm, op == 2'd1, to);
      if (to) begin
        push_fault(2'b10);
        return;
      end
    end
    e = '0;
    e.st = 3'd5;
    e.rwe = (src != 3'd0);
    e.pen = 1'b1;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", ctl_now(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    check("idle_state", 32'(state), 32'd0);
    check("idle_ctl", ctl_now(), 32'd0);
  endtask

  task automatic run(input logic [31:0] a_pc, input logic [31:0] a_alu,
                     input logic [1:0] op, input logic [3:0] mk,
                     input logic [2:0] f3, input logic [2:0] src,
                     input bit f3v, input int wf, input int wm,
                     input bit rst_mid_mem);
    int mem_seen;
    bit faulted;
    mem_seen = 0;
    faulted = 1'b0;
    build(a_pc, a_alu, op, mk, f3, src, f3v, wf, wm);
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        pc = a_pc;
        alu_result = a_alu;
        mem_op = op;
        mem_write_mask = mk;
        funct3 = f3;
        regfile_src = src;
        funct3_valid = f3v;
      end
      mem_ready = q[i].drv ? q[i].rdy : 1'($urandom_range(0, 1));
      #1;
      compare(q[i]);
      if (q[i].flt) faulted = 1'b1;
      if (rst_mid_mem && q[i].st == 3'd4) begin
        mem_seen++;
        if (mem_seen == 2) begin
          do_reset();
          return;
        end
      end
    end
    if (faulted) do_reset();
  endtask

  initial begin
    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [1:0]  r_op;
    int          r_wf;
    int          r_wm;
    #2;
    do_reset();
    // non-memory, zero wait
    run(32'h0, 32'h0, 2'd0, 4'h0, 3'b000, 3'd1, 1'b1, 0, 0, 1'b0);
    run(32'h4, 32'h0, 2'd0, 4'h0, 3'b000, 3'd1, 1'b1, 0, 0, 1'b0);
    // store with two wait cycles
    run(32'h8, 32'h100, 2'd2, 4'hF, 3'b010, 3'd0, 1'b1, 0, 2, 1'b0);
    // store again, reset in the middle of MEM
    run(32'hC, 32'h100, 2'd2, 4'hF, 3'b010, 3'd0, 1'b1, 0, 3, 1'b1);
    // load, zero wait
    run(32'h10, 32'h200, 2'd1, 4'hF, 3'b010, 3'd2, 1'b1, 0, 0, 1'b0);
    // illegal funct3
    run(32'h14, 32'h0, 2'd0, 4'h0, 3'b011, 3'd1, 1'b0, 0, 0, 1'b0);
    // fetch timeout
    run(32'h18, 32'h0, 2'd0, 4'h0, 3'b000, 3'd1, 1'b1, TO, 0, 1'b0);
    // misaligned word load
    run(32'h1C, 32'h102, 2'd1, 4'h0, 3'b010, 3'd2, 1'b1, 0, 0, 1'b0);
    // load timeout in MEM
    run(32'h20, 32'h300, 2'd1, 4'h0, 3'b010, 3'd2, 1'b1, 1, TO, 1'b0);
    for (int n = 0; n < 250; n++) begin
      r_pc = $urandom & 32'hFFFF_FFFC;
      r_alu = $urandom;
      if ($urandom_range(0, 1) == 0) r_alu = r_alu & 32'hFFFF_FFFC;
      r_op = 2'($urandom_range(0, 2));
      r_wf = ($urandom_range(0, 19) == 0) ? TO + int'($urandom_range(0, 1))
                                          : int'($urandom_range(0, 3));
      r_wm = ($urandom_range(0, 19) == 0) ? TO
                                          : int'($urandom_range(0, 3));
      run(r_pc, r_alu, r_op, 4'($urandom), 3'($urandom),
          3'($urandom), $urandom_range(0, 15) != 0, r_wf, r_wm,
          $urandom_range(0, 29) == 0 && r_op != 2'd0 && r_wm >= 2);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the rv32i_cpu core. It sequences each instruction through fetch, decode, execute, memory and writeback, and arbitrates the single shared memory port between instruction fetch and load/store traffic. It produces the enables that advance the PC, latch the instruction, latch load data and write the register file. Decoded fields (`mem_op`, `regfile_src`, `funct3_valid`, write mask) come from the core's control unit; encodings are the shared ones in `defines.v`.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of cycles `mem_req` may stay unanswered. 0 means unlimited.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc` in 32: current PC.
- `alu_result` in 32: effective address for load/store.
- `mem_op` in 2: `MEM_OP_NONE`/`LOAD`/`STORE`.
- `mem_write_mask` in 4: store byte mask from decode.
- `funct3` in 3: access size, taken from `funct3[1:0]` (00 byte, 01 half, 10 word).
- `regfile_src` in 3: `REG_SRC_NONE` suppresses the write.
- `funct3_valid` in 1: decode legality.
- `mem_ready` in 1: memory accepts or returns in the current cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store.
- `mem_wmask` out 4: byte enables.
- `mem_addr` out 32: access address.
- `instr_en` out 1: latch fetched instruction.
- `load_en` out 1: latch load data.
- `regfile_we` out 1: register file write.
- `pc_en` out 1: PC update / retire.
- `fault` out 1: sticky fault.
- `fault_cause` out 2: 01 illegal funct3, 10 timeout, 11 misaligned.
- `state` out 3: debug state.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- IDLE: all outputs 0. Lasts one cycle, then FETCH.
- FETCH:
  - `mem_req`=1, `mem_we`=0, `mem_wmask`=0, `mem_addr`=`pc`.
  - `mem_ready`=1 → `instr_en`=1 in the same cycle; next state DECODE.
- DECODE: one cycle.
  - `funct3_valid`=0 → FAULT, cause 01.
  - Otherwise → EXEC.
- EXEC: one cycle.
  - `mem_op`≠NONE → MEM.
  - Otherwise → WB.
- MEM:
  - `mem_req`=1, `mem_addr`=`alu_result`.
  - `mem_we`=1 only for STORE.
  - `mem_wmask`=`mem_write_mask` for STORE, 0 for LOAD.
  - `mem_ready`=1 → `load_en`=1 for LOAD only; next state WB.
- WB: one cycle.
  - `regfile_we`=(`regfile_src`≠`REG_SRC_NONE`).
  - `pc_en`=1.
  - Next state FETCH.
- FAULT:
  - Absorbing until reset.
  - `fault`=1; `fault_cause` holds its value.
  - All enables and `mem_req` are 0.
- Timeout:
  - 8-bit wait counter, cleared on entry to FETCH/MEM.
  - Increments each cycle `mem_req`=1 with `mem_ready`=0.
  - If `MEM_TIMEOUT`≠0 and `MEM_TIMEOUT` request cycles pass with no ready, the next state is FAULT, cause 10.
- The first fault wins. `fault_cause` is written only on entry to FAULT.

## Timing
- Reset: state=IDLE; all outputs 0, including `fault_cause`=00. Outputs drop asynchronously on `rst_n` fall, including mid-MEM.
- `instr_en`, `load_en` and `pc_en` are single-cycle pulses, gated combinationally by state and `mem_ready`.
- `mem_ready` may be combinational in the same cycle as `mem_req`.
- `mem_addr`, `mem_we` and `mem_wmask` stay stable while `mem_req`=1.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- `mem_ready` outside FETCH/MEM is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - In EXEC, for LOAD/STORE, misalignment goes to FAULT, cause 11, with no MEM request.
  - Misaligned means half with `alu_result[0]`=1, or word with `alu_result[1:0]`≠0.
- Undefined: no alignment check. The access proceeds with the unmodified address, and cause 11 is never produced.

## Test plan
- Zero-wait non-memory instruction: reset, `mem_ready`=1, `mem_op`=NONE, `regfile_src`=ALU, `pc`=0x0 → `state` 0,1,2,3,5,1. `mem_req`/`mem_addr`=0x0 in FETCH; `regfile_we`=`pc_en`=1 only in WB; 4 cycles per instruction.
- Store with wait, then reset: store, `alu_result`=0x100, mask 1111, `mem_ready` low 2 cycles in MEM → `mem_req`/`mem_we`/`mem_addr`=0x100 held 3 cycles; WB `regfile_we`=0. Repeat and drop `rst_n` mid-MEM → `mem_req` 0 immediately, `state`=0.
- Load: `mem_ready`=1 → `load_en` pulse in MEM, `mem_wmask`=0; WB `regfile_we`=1, `pc_en`=1.
- Illegal funct3: `funct3_valid`=0 in DECODE → `state`=7, `fault`=1, cause 01; no `pc_en` afterwards; state held until `rst_n`.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready`=0 in FETCH → `mem_req` high exactly 4 cycles, then FAULT, cause 10.
- Misaligned word load at `alu_result`=0x102:
  - With `MISALIGN_TRAP_EN`: FAULT, cause 11, no MEM-state `mem_req`.
  - Without it: MEM issues `mem_addr`=0x102.
